// File: rtl/prog_loader.sv
// prog_loader: write side of the program memory.
// Receives a framed byte stream from the host link and writes 16-bit
// instruction words into instruction memory at byte addresses stepping by 2.
// The DSP core is held in reset (core_hold) until a frame loads with a good
// checksum.
//
// Frame: SYNC, ADDR_HI (bits[3:0] used), ADDR_LO, COUNT (0 = 256 words),
//        COUNT x {DATA_HI, DATA_LO}, CSUM
//        CSUM = 8-bit sum of every byte after SYNC (excluding CSUM itself).
//
// Handshake: a byte transfers on a rising edge where in_valid & in_ready.
//   in_ready is 0 only while in reset and for the first cycle after it; the
//   loader never back-pressures after that. in_valid may drop at any time.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_data    host byte stream
//   in_ready            loader accepts a byte
//   imem_wr_en          one-cycle write strobe
//   imem_wr_addr        write byte address (ADDR_W bits)
//   imem_wr_data        write word {DATA_HI, DATA_LO}
//   core_hold           1 = DSP held in reset
//   done                sticky: last frame loaded with a good checksum
//   error               sticky: last frame had a bad checksum or timed out
//   state_dbg           current FSM state (IDLE encodes as 0)
module prog_loader #(
  parameter int          ADDR_W  = 12,
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int          TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [15:0]       imem_wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA_HI, S_DATA_LO, S_CHECK
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        csum_q, csum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [3:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        words_q, words_d;
  logic [7:0]        dhi_q, dhi_d;
  logic              ready_q;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;

  assign accept       = in_valid & ready_q;
  assign in_ready     = ready_q;
  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign core_hold    = hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign state_dbg    = state_q;

  always_comb begin
    state_d   = state_q;
    csum_d    = csum_q;
    tmo_d     = tmo_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    words_d   = words_q;
    dhi_d     = dhi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    error_d   = error_q;

    // Inter-byte watchdog: only runs mid-frame, cleared by any accepted byte.
    // The abort fires on the TIMEOUT-th consecutive idle cycle.
    if (state_q != S_IDLE) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        tmo_d   = '0;
        state_d = S_IDLE;
        error_d = 1'b1;
        done_d  = 1'b0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == SYNC) begin
            done_d  = 1'b0;
            error_d = 1'b0;
            csum_d  = 8'h00;
            hold_d  = 1'b1;
            state_d = S_ADDR_HI;
          end
        end
        S_ADDR_HI: begin
          hi_d    = in_data[3:0];
          csum_d  = csum_q + in_data;
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d  = ADDR_W'({hi_q, in_data});
          csum_d  = csum_q + in_data;
          state_d = S_COUNT;
        end
        S_COUNT: begin
          words_d = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          csum_d  = csum_q + in_data;
          state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          dhi_d   = in_data;
          csum_d  = csum_q + in_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {dhi_q, in_data};
          // Address wraps naturally at 2^ADDR_W; odd start addresses stay odd.
          addr_d    = addr_q + ADDR_W'(2);
          words_d   = words_q - 9'd1;
          csum_d    = csum_q + in_data;
          state_d   = (words_q == 9'd1) ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: begin
          if (in_data == csum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      csum_q    <= 8'h00;
      tmo_q     <= '0;
      hi_q      <= 4'h0;
      addr_q    <= '0;
      words_q   <= 9'd0;
      dhi_q     <= 8'h00;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 16'h0000;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      csum_q    <= csum_d;
      tmo_q     <= tmo_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      dhi_q     <= dhi_d;
      ready_q   <= 1'b1;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

endmodule
